// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage.
// Owns the PC, addresses the combinational instruction ROM and buffers
// {pc, instr} pairs in a small prefetch queue that feeds decode over a
// valid/ready handshake. A redirect flushes the queue and reloads the PC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned target raises a sticky fault
//               that blocks fetch until an aligned redirect (or reset).
//   undefined : the two low bits of the redirect target are ignored and fault
//               is held at 0.
module ifetch_unit #(
   parameter int              PC_W     = 8,
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-3:0] imem_addr,
   input  logic [31:0]     imem_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [PC_W-1:0] out_pc,
   output logic [PC_W-1:0] out_pcplus4,
   output logic            fault
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fault_q, fault_d;

   // Queue storage is deliberately left without reset; only the pointers
   // and count decide what is visible.
   logic [PC_W-1:0]  pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];

   logic             pop;
   logic             push;
   logic [PC_W-1:0]  target_pc;
   logic             target_misaligned;

   // Redirect target qualification: with the alignment check the full byte
   // address is loaded and misalignment is flagged; without it the low bits
   // are masked off.
   always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
      target_pc         = redirect_pc;
      target_misaligned = |redirect_pc[1:0];
`else
      target_pc         = redirect_pc & ~PC_W'(3);
      target_misaligned = 1'b0;
`endif
   end

   // Handshake and next-state for PC, pointers, count and fault.
   always_comb begin
      pop      = out_valid & out_ready;
      push     = ~redirect & ~fault_q & ((count_q < CNT_W'(DEPTH)) | pop);
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      fault_d  = fault_q;
      if (redirect) begin
         // Flush wins over everything, including a same-cycle pop.
         pc_d     = target_pc;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         fault_d  = target_misaligned;
      end else begin
         if (push) begin
            pc_d     = pc_q + PC_W'(4);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         fault_q  <= fault_d;
      end
   end

   // Queue entry write at the tail on each push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= pc_q;
         instr_mem_q[wr_ptr_q] <= imem_instr;
      end
   end

   // Head presentation: outputs read registered storage and are zeroed
   // whenever the queue is empty.
   always_comb begin
      out_valid   = (count_q != '0);
      out_pc      = '0;
      out_instr   = '0;
      out_pcplus4 = '0;
      if (out_valid) begin
         out_pc      = pc_mem_q[rd_ptr_q];
         out_instr   = instr_mem_q[rd_ptr_q];
         out_pcplus4 = pc_mem_q[rd_ptr_q] + PC_W'(4);
      end
   end

   assign imem_addr = pc_q[PC_W-1:2];
   assign fault     = fault_q;

endmodule
